// File: rtl/sobel_row_scheduler.sv
// Frame sequencer for the sobel datapath: primes a PRE_ROWS-deep line buffer, then
// interleaves per-row compute with the next row load, under an ap_ctrl_hs upstream handshake.
module sobel_row_scheduler #(
  parameter int PRE_ROWS = 2,
  parameter int ROW_W    = 16,
  parameter int CNT_W    = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic             ap_continue,
  input  logic [ROW_W-1:0] height,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ld_start,
  output logic [ROW_W-1:0] ld_row,
  input  logic             ld_done,
  output logic             cmp_start,
  output logic [ROW_W-1:0] cmp_row,
  input  logic             cmp_done,
  output logic [CNT_W-1:0] busy_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE_LD  = 3'd1,
    S_ROW_CMP = 3'd2,
    S_ROW_LD  = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  // Row arithmetic is done one bit wider so r+PRE_ROWS cannot wrap near the top of the range.
  localparam int XW = ROW_W + 1;
  localparam logic [XW-1:0] PRE_X = XW'(PRE_ROWS);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] h_q, h_nxt;
  logic [ROW_W-1:0] p_q, p_nxt;
  logic [ROW_W-1:0] r_q, r_nxt;
  logic [CNT_W-1:0] busy_nxt;

  logic [XW-1:0] h_x, p_inc_x, r_inc_x, r_ahead_x, pre_tgt_x;
  logic          in_busy;

  assign h_x       = {1'b0, h_q};
  assign p_inc_x   = {1'b0, p_q} + XW'(1);
  assign r_inc_x   = {1'b0, r_q} + XW'(1);
  assign r_ahead_x = {1'b0, r_q} + PRE_X;
  assign pre_tgt_x = (h_x < PRE_X) ? h_x : PRE_X;

  assign in_busy = (state == S_PRE_LD) || (state == S_ROW_CMP) || (state == S_ROW_LD);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= S_IDLE;
      h_q         <= '0;
      p_q         <= '0;
      r_q         <= '0;
      busy_cycles <= '0;
    end else begin
      state       <= state_nxt;
      h_q         <= h_nxt;
      p_q         <= p_nxt;
      r_q         <= r_nxt;
      busy_cycles <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h_q;
    p_nxt     = p_q;
    r_nxt     = r_q;
    busy_nxt  = busy_cycles;

    if (in_busy && (busy_cycles != {CNT_W{1'b1}}))
      busy_nxt = busy_cycles + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (ap_start) begin
          h_nxt     = height;
          p_nxt     = '0;
          r_nxt     = '0;
          busy_nxt  = '0;
          state_nxt = (height == '0) ? S_FIN : S_PRE_LD;
        end
      end
      S_PRE_LD: begin
        if (ld_done) begin
          p_nxt = p_q + ROW_W'(1);
          if (p_inc_x == pre_tgt_x) state_nxt = S_ROW_CMP;
        end
      end
      S_ROW_CMP: begin
        // Either fetch the row PRE_ROWS ahead, or drain the buffered tail without loading.
        if (cmp_done) begin
          if (r_ahead_x < h_x)     state_nxt = S_ROW_LD;
          else if (r_inc_x == h_x) state_nxt = S_FIN;
          else                     r_nxt     = r_q + ROW_W'(1);
        end
      end
      S_ROW_LD: begin
        if (ld_done) begin
          r_nxt     = r_q + ROW_W'(1);
          state_nxt = S_ROW_CMP;
        end
      end
      S_FIN: begin
        if (ap_continue) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ap_idle   = (state == S_IDLE);
  assign ap_ready  = ap_idle && ap_start && ap_rst_n;
  assign ap_done   = (state == S_FIN);
  assign ld_start  = (state == S_PRE_LD) || (state == S_ROW_LD);
  assign cmp_start = (state == S_ROW_CMP);

  always_comb begin
    ld_row = '0;
    if (state == S_PRE_LD)      ld_row = p_q;
    else if (state == S_ROW_LD) ld_row = r_ahead_x[ROW_W-1:0];
  end

  assign cmp_row = (state == S_ROW_CMP) ? r_q : '0;

endmodule

// File: doc/sobel_row_scheduler.md
Name: sobel_row_scheduler

Overview:
- Top-level sequencer for the sobel datapath.
- Drives the ap_ctrl_hs handshakes of two sub-blocks so a frame of `height` rows is processed with a `PRE_ROWS`-deep line buffer:
  - line-load loop (ld_*, the VITIS_LOOP_88_1 engine)
  - per-row compute loop (cmp_*, the VITIS_LOOP_118_3 engine)
- Exposes the standard ap_start/ap_done/ap_idle/ap_ready/ap_continue interface upstream.
- Reports a busy-cycle count for the dataflow monitors.

Parameters:
- PRE_ROWS, 2, number of rows loaded into the line buffer before the first compute (1..8).
- ROW_W, 16, width of row counters and of `height`.
- CNT_W, 32, width of busy_cycles.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- ap_start  in  1  frame request; sampled only in IDLE.
- ap_continue  in  1  releases ap_done.
- height  in  ROW_W  rows in the frame; latched when the start is accepted.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse when the start is accepted.
- ap_done  out  1  high in FIN.
- ld_start  out  1  start to the load engine.
- ld_row  out  ROW_W  row index to load; valid while ld_start is high.
- ld_done  in  1  load engine completion.
- cmp_start  out  1  start to the compute engine.
- cmp_row  out  ROW_W  row index to compute; valid while cmp_start is high.
- cmp_done  in  1  compute engine completion.
- busy_cycles  out  CNT_W  cycles spent in PRE_LD/ROW_CMP/ROW_LD for the last or current frame.

Behaviour:
- Reset (async, ap_rst_n=0):
  - State goes to IDLE; all counters are 0.
  - Outputs: ap_idle=1; ap_ready=0, ap_done=0, ld_start=0, cmp_start=0, ld_row=0, cmp_row=0, busy_cycles=0.
  - Reset mid-frame abandons the frame immediately; no further starts are issued.
- State machine (registered, one state per cycle minimum):
  - IDLE: ap_idle=1. On ap_start=1: latch height to H, set ap_ready=1 for exactly one cycle, clear busy_cycles and the counters p and r.
    - H==0: go to FIN.
    - otherwise: go to PRE_LD.
  - PRE_LD: ld_start=1, ld_row=p. ld_start is held until ld_done=1 is sampled; ld_done in the first cycle is accepted.
    - On ld_done: p <= p+1.
    - If p+1 == min(PRE_ROWS, H): go to ROW_CMP; else stay in PRE_LD with ld_start dropping for 0 cycles (back-to-back allowed).
  - ROW_CMP: cmp_start=1, cmp_row=r, held until cmp_done=1.
    - On cmp_done, if r+PRE_ROWS < H: go to ROW_LD.
    - On cmp_done, else if r+1 == H: go to FIN.
    - On cmp_done, else: r <= r+1, stay in ROW_CMP.
  - ROW_LD: ld_start=1, ld_row=r+PRE_ROWS, held until ld_done.
    - On ld_done: r <= r+1, go to ROW_CMP.
  - FIN: ap_done=1, held until ap_continue=1.
    - ap_continue=1 in the FIN entry cycle still exits; go to IDLE next cycle.
    - ap_start is ignored in FIN.
- Handshakes:
  - ld_start and cmp_start are never high simultaneously.
  - done inputs are ignored when the matching start is low.
  - A start output deasserts in the cycle after its done is sampled unless the FSM re-enters the same state.
- busy_cycles:
  - +1 every cycle in PRE_LD, ROW_CMP or ROW_LD.
  - Saturates at all-ones.
  - Holds its value in FIN and IDLE until the next accepted start.
- Row order is fixed at PRE_ROWS=2, H=4: ld0 ld1 cmp0 ld2 cmp1 ld3 cmp2 cmp3.
- height changes after acceptance have no effect.

Test Plan:
1. PRE_ROWS=2, height=4, ld_done/cmp_done tied to their starts → start sequence ld0,ld1,cmp0,ld2,cmp1,ld3,cmp2,cmp3; ap_done asserts after 8 busy cycles; busy_cycles=8; ap_ready pulses once.
2. height=1 → ld0, cmp0 only (no ld1); busy_cycles=2; ap_done held high for 5 cycles with ap_continue=0, then drops one cycle after ap_continue=1.
3. height=0 → ap_ready pulse, then ap_done on the next cycle; ld_start and cmp_start never assert; busy_cycles=0.
4. height=3, cmp_done delayed 3 cycles per row, ld_done immediate → cmp_start held 4 cycles per row with cmp_row stable; busy_cycles=2+4+1+4+4=15.
5. ap_rst_n pulsed low during ROW_CMP with row 1 in flight → cmp_start=0 and ap_idle=1 asynchronously; a new start with height=2 then runs ld0,ld1,cmp0,cmp1.
6. ap_start held high through FIN with ap_continue=1 at FIN entry → IDLE for 1 cycle, then a second frame is accepted with a second ap_ready pulse; busy_cycles is cleared at acceptance.
